// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load/store into one or two word-aligned,
// byte-enabled req/ack bus beats, with sign/zero extension of load results.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_wr,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [2:0]               req_funct3,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t      state;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic        split;
  logic [3:0]  be_hi;
  logic [31:0] beat0_data;

  logic [7:0]  req_mask;
  logic        req_split;

  function automatic logic [2:0] size_bytes(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] f, input logic [1:0] o);
    logic [7:0] m;
    case (f[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0f;
    endcase
    return m << o;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] o);
    return 32'(({w, w} << {o, 3'b000}) >> 32);
  endfunction

  function automatic logic [31:0] load_extend(input logic [63:0] data, input logic [1:0] o,
                                              input logic [2:0] f);
    logic [31:0] s;
    s = 32'(data >> {o, 3'b000});
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // The upper nibble of the shifted mask is the lane set for the second beat.
  assign req_mask  = lane_mask(req_funct3, req_addr[1:0]);
  assign req_split = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off       <= req_addr[1:0];
            f3        <= req_funct3;
            split     <= req_split;
            be_hi     <= req_mask[7:4];
            mem_req   <= 1'b1;
            mem_we    <= req_wr;
            mem_addr  <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata <= rotl_bytes(req_wdata, req_addr[1:0]);
            mem_be    <= req_mask[3:0];
            state     <= BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (split) begin
              beat0_data <= mem_rdata;
              mem_addr   <= mem_addr + ADDRESS_WIDTH'(4);
              mem_be     <= be_hi;
              state      <= BEAT1;
            end else begin
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              if (!mem_we) resp_rdata <= load_extend({32'd0, mem_rdata}, off, f3);
              state      <= DONE;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            if (!mem_we) resp_rdata <= load_extend({mem_rdata, beat0_data}, off, f3);
            state      <= DONE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
